rv_multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle RV32I core.
- Sequences fetch, decode, execute, memory and writeback over the shared ALU, register file and unified memory port.
- Drives the 2-bit ALU operation class consumed by the ALU control decoder: 00 add, 01 sub, 10 R-type, 11 I-type.
- Issues memory requests with a ready handshake and retires exactly one instruction per sequence.

---
 rtl/rv_multicycle_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// Main control FSM for the multi-cycle RV32I core.
// Optional macro RV_MCTRL_ILLEGAL_TRAP_EN makes ILLEGAL a terminal trap state.
module rv_multicycle_ctrl #(
  parameter int unsigned RESET_STALL = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       br_cond,
  input  logic       mem_ready,
  output logic [1:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic       addr_sel,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       instr_done,
  output logic [3:0] state_dbg
`ifdef RV_MCTRL_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_instr
`endif
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    ALU_WB   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WB   = 4'd7,
    MEM_WR   = 4'd8,
    BRANCH   = 4'd9,
    JAL      = 4'd10,
    JALR     = 4'd11,
    JALR_WB  = 4'd12,
    LUI      = 4'd13,
    AUIPC    = 4'd14,
    ILLEGAL  = 4'd15
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       stalled;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
      cnt_q   <= 4'(RESET_STALL);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stalled = (cnt_q != 4'd0);

  // Outputs are forced low while rst_n is low so no strobe escapes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = stalled ? cnt_q - 4'd1 : cnt_q;
    alu_op     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    addr_sel   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = 2'b00;
    instr_done = 1'b0;
    state_dbg  = 4'd0;
`ifdef RV_MCTRL_ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    if (rst_n) begin
      state_dbg = state_q;
      unique case (state_q)
        FETCH: begin
          alu_src_b = 2'b10;
          if (!stalled) begin
            mem_req = 1'b1;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
              state_d  = DECODE;
            end
          end
        end
        DECODE: begin
          alu_src_b = 2'b01;
          unique case (opcode)
            7'b0110011: state_d = EXEC_R;
            7'b0010011: state_d = EXEC_I;
            7'b0000011: state_d = MEM_ADDR;
            7'b0100011: state_d = MEM_ADDR;
            7'b1100011: state_d = BRANCH;
            7'b1101111: state_d = JAL;
            7'b1100111: state_d = JALR;
            7'b0110111: state_d = LUI;
            7'b0010111: state_d = AUIPC;
            default:    state_d = ILLEGAL;
          endcase
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
          state_d   = ALU_WB;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b01;
          alu_op    = 2'b11;
          state_d   = ALU_WB;
        end
        ALU_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b01;
          // opcode bit 5 separates store (0100011) from load (0000011)
          state_d   = opcode[5] ? MEM_WR : MEM_RD;
        end
        MEM_RD: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) state_d = MEM_WB;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          wb_sel     = 2'b01;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        MEM_WR: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = FETCH;
          end
        end
        BRANCH: begin
          alu_src_a  = 1'b1;
          alu_op     = 2'b01;
          pc_write   = br_cond;
          pc_src     = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        JAL, JALR_WB: begin
          reg_write  = 1'b1;
          wb_sel     = 2'b10;
          pc_write   = 1'b1;
          pc_src     = 1'b1;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        JALR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b01;
          state_d   = JALR_WB;
        end
        LUI: begin
          reg_write  = 1'b1;
          wb_sel     = 2'b11;
          instr_done = 1'b1;
          state_d    = FETCH;
        end
        AUIPC: begin
          alu_src_b = 2'b01;
          state_d   = ALU_WB;
        end
        ILLEGAL: begin
`ifdef RV_MCTRL_ILLEGAL_TRAP_EN
          illegal_instr = 1'b1;
          state_d       = ILLEGAL;
`else
          instr_done = 1'b1;
          state_d    = FETCH;
`endif
        end
        default: state_d = FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Scoreboard bench for rv_multicycle_ctrl: directed per-cycle vectors,
// checked by an independent negedge monitor.
module tb_rv_multicycle_ctrl;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       br_cond;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       addr_sel;
  logic       mem_req;
  logic       mem_we;
  logic       ir_write;
  logic       pc_write;
  logic       pc_src;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       instr_done;
  logic [3:0] state_dbg;
  logic       ill;

  rv_multicycle_ctrl #(.RESET_STALL(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .opcode(opcode),
    .br_cond(br_cond),
    .mem_ready(mem_ready),
    .alu_op(alu_op),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .addr_sel(addr_sel),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .ir_write(ir_write),
    .pc_write(pc_write),
    .pc_src(pc_src),
    .reg_write(reg_write),
    .wb_sel(wb_sel),
    .instr_done(instr_done),
    .state_dbg(state_dbg)
`ifdef RV_MCTRL_ILLEGAL_TRAP_EN
    ,
    .illegal_instr(ill)
`endif
  );

`ifndef RV_MCTRL_ILLEGAL_TRAP_EN
  assign ill = 1'b0;
`endif

  typedef struct {
    logic [19:0] v;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JR  = 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_BAD = 7'b0000000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // il st aop sa sb asel req we irw pcw pcs rw wb done
  function automatic logic [19:0] o(
    input int il, input int st, input int aop,
    input int sa, input int sb, input int as_,
    input int rq, input int we, input int irw,
    input int pcw, input int pcs, input int rw,
    input int wb, input int dn);
    return {1'(il), 4'(st), 2'(aop), 1'(sa),
            2'(sb), 1'(as_), 1'(rq), 1'(we),
            1'(irw), 1'(pcw), 1'(pcs), 1'(rw),
            2'(wb), 1'(dn)};
  endfunction

  logic [19:0] act;
  assign act = {ill, state_dbg, alu_op, alu_src_a,
                alu_src_b, addr_sel, mem_req, mem_we,
                ir_write, pc_write, pc_src, reg_write,
                wb_sel, instr_done};

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (act !== e.v) begin
        n_mis++;
        $display("FAIL %s: got %h want %h", e.nm, act, e.v);
      end
    end
  end

  task automatic step(input logic r, input logic [6:0] opc,
                      input logic bc, input logic rdy,
                      input logic [19:0] e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n     = r;
    opcode    = opc;
    br_cond   = bc;
    mem_ready = rdy;
    x.v  = e;
    x.nm = nm;
    q.push_back(x);
  endtask

  logic [19:0] z, fs, fw, fr, dec, awb, ma;

  initial begin
    rst_n     = 1'b0;
    opcode    = 7'd0;
    br_cond   = 1'b0;
    mem_ready = 1'b0;
    z   = 20'h0;
    fs  = o(0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    fw  = o(0, 0, 0, 0, 2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    fr  = o(0, 0, 0, 0, 2, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    dec = o(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    awb = o(0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    ma  = o(0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    step(0, OP_R, 0, 1, z, "rst_a");
    step(0, OP_R, 0, 1, z, "rst_b");
    // stall cycles ignore mem_ready
    step(1, OP_R, 0, 1, fs, "stall2");
    step(1, OP_R, 0, 1, fs, "stall1");

    step(1, OP_R, 0, 1, fr, "add_f");
    step(1, OP_R, 0, 1, dec, "add_d");
    step(1, OP_R, 0, 1,
         o(0, 2, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "add_x");
    step(1, OP_R, 0, 1, awb, "add_wb");

    step(1, OP_I, 0, 1, fr, "addi_f");
    step(1, OP_I, 0, 1, dec, "addi_d");
    step(1, OP_I, 0, 1,
         o(0, 3, 3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "addi_x");
    step(1, OP_I, 0, 1, awb, "addi_wb");

    step(1, OP_LD, 0, 1, fr, "lw_f");
    step(1, OP_LD, 0, 1, dec, "lw_d");
    step(1, OP_LD, 0, 1, ma, "lw_a");
    for (int i = 0; i < 3; i++)
      step(1, OP_LD, 0, 0,
           o(0, 6, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "lw_wait");
    step(1, OP_LD, 0, 1,
         o(0, 6, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0), "lw_rd");
    step(1, OP_LD, 0, 1,
         o(0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1), "lw_wb");

    step(1, OP_ST, 0, 0, fw, "sw_fw");
    step(1, OP_ST, 0, 1, fr, "sw_f");
    step(1, OP_ST, 0, 1, dec, "sw_d");
    step(1, OP_ST, 0, 1, ma, "sw_a");
    step(1, OP_ST, 0, 1,
         o(0, 8, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1), "sw_wr");

    step(1, OP_BR, 1, 1, fr, "beq1_f");
    step(1, OP_BR, 1, 1, dec, "beq1_d");
    step(1, OP_BR, 1, 1,
         o(0, 9, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1), "beq1_x");
    step(1, OP_BR, 0, 1, fr, "beq0_f");
    step(1, OP_BR, 0, 1, dec, "beq0_d");
    step(1, OP_BR, 0, 1,
         o(0, 9, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), "beq0_x");

    step(1, OP_JAL, 0, 1, fr, "jal_f");
    step(1, OP_JAL, 0, 1, dec, "jal_d");
    step(1, OP_JAL, 0, 1,
         o(0, 10, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 1), "jal_x");

    step(1, OP_JR, 0, 1, fr, "jalr_f");
    step(1, OP_JR, 0, 1, dec, "jalr_d");
    step(1, OP_JR, 0, 1,
         o(0, 11, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "jalr_x");
    step(1, OP_JR, 0, 1,
         o(0, 12, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 1), "jalr_wb");

    step(1, OP_LUI, 0, 1, fr, "lui_f");
    step(1, OP_LUI, 0, 1, dec, "lui_d");
    step(1, OP_LUI, 0, 1,
         o(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1), "lui_x");

    step(1, OP_AUI, 0, 1, fr, "aui_f");
    step(1, OP_AUI, 0, 1, dec, "aui_d");
    step(1, OP_AUI, 0, 1,
         o(0, 14, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "aui_x");
    step(1, OP_AUI, 0, 1, awb, "aui_wb");

    step(1, OP_BAD, 0, 1, fr, "ill_f");
    step(1, OP_BAD, 0, 1, dec, "ill_d");
`ifdef RV_MCTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      step(1, OP_BAD, 0, 1,
           o(1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "ill_hold");
    step(0, OP_ST, 0, 1, z, "ill_rst");
    step(1, OP_ST, 0, 1, fs, "ill_stall2");
    step(1, OP_ST, 0, 1, fs, "ill_stall1");
`else
    step(1, OP_BAD, 0, 1,
         o(0, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), "ill_nop");
`endif

    // reset during store wait aborts and re-applies the stall
    step(1, OP_ST, 0, 1, fr, "rs_f");
    step(1, OP_ST, 0, 1, dec, "rs_d");
    step(1, OP_ST, 0, 1, ma, "rs_a");
    step(1, OP_ST, 0, 0,
         o(0, 8, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0), "rs_wait");
    step(0, OP_ST, 0, 1, z, "rs_mid");
    step(1, OP_LUI, 0, 1, fs, "rs_stall2");
    step(1, OP_LUI, 0, 1, fs, "rs_stall1");
    step(1, OP_LUI, 0, 1, fr, "rs_fetch");
    step(1, OP_LUI, 0, 1, dec, "rs_d2");
    step(1, OP_LUI, 0, 1,
         o(0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1), "rs_lui");

    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_mis);
    $finish;
  end

endmodule
